// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: pipeline-register enables, bubbles, redirect tracking, stall watchdog.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds saturating D-stall / I-stall / load-use counters).
module pipe_hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              icache_stall_i,
    input  logic              dcache_stall_i,
    input  logic              branch_taken_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [REG_AW-1:0] ID_EX_Rd_i,
    input  logic [REG_AW-1:0] IF_ID_Rs1_i,
    input  logic [REG_AW-1:0] IF_ID_Rs2_i,
    output logic              PC_write_o,
    output logic              IF_ID_write_o,
    output logic              ID_EX_write_o,
    output logic              EX_MEM_write_o,
    output logic              MEM_WB_write_o,
    output logic              IF_ID_flush_o,
    output logic              ID_EX_flush_o,
    output logic [1:0]        state_o,
    output logic              stall_timeout_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_dstall_o,
    output logic [CNT_W-1:0]  perf_istall_o,
    output logic [CNT_W-1:0]  perf_lu_o
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, ISTALL = 2'd1, DSTALL = 2'd2} state_t;
    typedef enum logic [2:0] {C_NONE, C_DSTALL, C_BRANCH, C_ISTALL, C_REDIR, C_LU} cause_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    state_t          state_q, state_d;
    cause_t          cause;
    logic            redir_pend_q, redir_pend_d;
    logic            lu;
    logic [WD_W-1:0] wd_cnt;

    assign lu = ID_EX_MemRead_i && (ID_EX_Rd_i != '0) &&
                ((ID_EX_Rd_i == IF_ID_Rs1_i) || (ID_EX_Rd_i == IF_ID_Rs2_i));

    always_comb begin
        cause = C_NONE;
        if (dcache_stall_i)      cause = C_DSTALL;
        else if (branch_taken_i) cause = C_BRANCH;
        else if (icache_stall_i) cause = C_ISTALL;
        else if (redir_pend_q)   cause = C_REDIR;
        else if (lu)             cause = C_LU;
    end

    always_comb begin
        PC_write_o     = 1'b1;
        IF_ID_write_o  = 1'b1;
        ID_EX_write_o  = 1'b1;
        EX_MEM_write_o = 1'b1;
        MEM_WB_write_o = 1'b1;
        IF_ID_flush_o  = 1'b0;
        ID_EX_flush_o  = 1'b0;
        redir_pend_d   = redir_pend_q;
        state_d        = RUN;
        case (cause)
            C_DSTALL: begin
                // Branch stays frozen in EX and re-asserts once the D-miss resolves.
                PC_write_o     = 1'b0;
                IF_ID_write_o  = 1'b0;
                ID_EX_write_o  = 1'b0;
                EX_MEM_write_o = 1'b0;
                MEM_WB_write_o = 1'b0;
                state_d        = DSTALL;
            end
            C_BRANCH: begin
                IF_ID_flush_o = 1'b1;
                ID_EX_flush_o = 1'b1;
                if (icache_stall_i) begin
                    redir_pend_d = 1'b1;
                    state_d      = ISTALL;
                end else begin
                    redir_pend_d = 1'b0;
                end
            end
            C_ISTALL: begin
                PC_write_o    = 1'b0;
                IF_ID_write_o = 1'b0;
                ID_EX_flush_o = 1'b1;
                state_d       = ISTALL;
            end
            C_REDIR: begin
                // Instruction returned by the stalled fetch is wrong-path.
                IF_ID_flush_o = 1'b1;
                redir_pend_d  = 1'b0;
            end
            C_LU: begin
                PC_write_o    = 1'b0;
                IF_ID_write_o = 1'b0;
                ID_EX_flush_o = 1'b1;
            end
            default: ;
        endcase
        if (!rst_i) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_write_o  = 1'b0;
            EX_MEM_write_o = 1'b0;
            MEM_WB_write_o = 1'b0;
            IF_ID_flush_o  = 1'b0;
            ID_EX_flush_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= RUN;
            redir_pend_q    <= 1'b0;
            wd_cnt          <= '0;
            stall_timeout_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            redir_pend_q <= redir_pend_d;
            if (icache_stall_i || dcache_stall_i) begin
                if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
                if (wd_cnt == WD_MAX - 1'b1) stall_timeout_o <= 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end

    assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_dstall_o <= '0;
            perf_istall_o <= '0;
            perf_lu_o     <= '0;
        end else begin
            if (cause == C_DSTALL && perf_dstall_o != '1) perf_dstall_o <= perf_dstall_o + 1'b1;
            if (cause == C_ISTALL && perf_istall_o != '1) perf_istall_o <= perf_istall_o + 1'b1;
            if (cause == C_LU && perf_lu_o != '1)         perf_lu_o     <= perf_lu_o + 1'b1;
        end
    end
`else
    logic cnt_w_unused;
    assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT = 8).
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;

    // ctl = {PC, IF_ID, ID_EX, EX_MEM, MEM_WB writes, IF_ID_flush, ID_EX_flush}
    localparam logic [6:0] C_ZERO   = 7'b00000_00;
    localparam logic [6:0] C_FREE   = 7'b11111_00;
    localparam logic [6:0] C_BRANCH = 7'b11111_11;
    localparam logic [6:0] C_ISTALL = 7'b00111_01;
    localparam logic [6:0] C_REDIR  = 7'b11111_10;
    localparam logic [6:0] C_LU     = 7'b00111_01;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              icache_stall_i = 1'b0;
    logic              dcache_stall_i = 1'b0;
    logic              branch_taken_i = 1'b0;
    logic              ID_EX_MemRead_i = 1'b0;
    logic [REG_AW-1:0] ID_EX_Rd_i = '0;
    logic [REG_AW-1:0] IF_ID_Rs1_i = '0;
    logic [REG_AW-1:0] IF_ID_Rs2_i = '0;
    logic PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o, MEM_WB_write_o;
    logic IF_ID_flush_o, ID_EX_flush_o, stall_timeout_o;
    logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_dstall_o, perf_istall_o, perf_lu_o;
`endif
    logic [6:0] ctl;

    int checks = 0;
    int errors = 0;

    assign ctl = {PC_write_o, IF_ID_write_o, ID_EX_write_o, EX_MEM_write_o,
                  MEM_WB_write_o, IF_ID_flush_o, ID_EX_flush_o};

    always #5 clk_i = ~clk_i;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .TIMEOUT(8), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .icache_stall_i(icache_stall_i), .dcache_stall_i(dcache_stall_i),
        .branch_taken_i(branch_taken_i), .ID_EX_MemRead_i(ID_EX_MemRead_i),
        .ID_EX_Rd_i(ID_EX_Rd_i), .IF_ID_Rs1_i(IF_ID_Rs1_i), .IF_ID_Rs2_i(IF_ID_Rs2_i),
        .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o), .ID_EX_write_o(ID_EX_write_o),
        .EX_MEM_write_o(EX_MEM_write_o), .MEM_WB_write_o(MEM_WB_write_o),
        .IF_ID_flush_o(IF_ID_flush_o), .ID_EX_flush_o(ID_EX_flush_o),
        .state_o(state_o), .stall_timeout_o(stall_timeout_o)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_dstall_o(perf_dstall_o), .perf_istall_o(perf_istall_o), .perf_lu_o(perf_lu_o)
`endif
    );

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        icache_stall_i = 0; dcache_stall_i = 0; branch_taken_i = 0;
        ID_EX_MemRead_i = 0; ID_EX_Rd_i = '0; IF_ID_Rs1_i = '0; IF_ID_Rs2_i = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 0;
        #2;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", stall_timeout_o); end
        tick(); tick();
        rst_i = 1;
        #1;
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_FREE); end
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_release_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_load_use();
        ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd5; IF_ID_Rs1_i = 5'd5; IF_ID_Rs2_i = 5'd9;
        #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs1: got %b expected %b", ctl, C_LU); end
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL lu_state: got %0d expected 0", state_o); end
        ID_EX_MemRead_i = 0;   // bubble now in EX
        #1;
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL lu_one_bubble: got %b expected %b", ctl, C_FREE); end
        tick();
        ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd7; IF_ID_Rs1_i = 5'd1; IF_ID_Rs2_i = 5'd7;
        #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs2: got %b expected %b", ctl, C_LU); end
        tick();
        ID_EX_Rd_i = 5'd0; IF_ID_Rs1_i = 5'd0; IF_ID_Rs2_i = 5'd0;
        #1;
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL lu_rd_zero: got %b expected %b", ctl, C_FREE); end
        tick();
        ID_EX_MemRead_i = 0; ID_EX_Rd_i = 5'd4; IF_ID_Rs1_i = 5'd4;
        #1;
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL lu_not_load: got %b expected %b", ctl, C_FREE); end
        tick();
        idle_inputs();
    endtask

    task automatic test_dstall();
        dcache_stall_i = 1; branch_taken_i = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL dstall_ctl[%0d]: got %b expected %b", i, ctl, C_ZERO); end
            tick();
            checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL dstall_state[%0d]: got %0d expected 2", i, state_o); end
        end
        dcache_stall_i = 0;
        #1;
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL dstall_redirect: got %b expected %b", ctl, C_BRANCH); end
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL dstall_exit_state: got %0d expected 0", state_o); end
        idle_inputs();
    endtask

    task automatic test_istall();
        icache_stall_i = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (ctl !== C_ISTALL) begin errors++; $display("FAIL istall_ctl[%0d]: got %b expected %b", i, ctl, C_ISTALL); end
            tick();
            checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL istall_state[%0d]: got %0d expected 1", i, state_o); end
        end
        icache_stall_i = 0;
        #1;
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL istall_release: got %b expected %b", ctl, C_FREE); end
        tick();
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL istall_exit_state: got %0d expected 0", state_o); end
    endtask

    task automatic test_redirect();
        branch_taken_i = 1; icache_stall_i = 1;
        #1;
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL redir_branch: got %b expected %b", ctl, C_BRANCH); end
        tick();
        checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL redir_state: got %0d expected 1", state_o); end
        branch_taken_i = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (ctl !== C_ISTALL) begin errors++; $display("FAIL redir_istall[%0d]: got %b expected %b", i, ctl, C_ISTALL); end
            tick();
        end
        icache_stall_i = 0;
        ID_EX_MemRead_i = 1; ID_EX_Rd_i = 5'd3; IF_ID_Rs1_i = 5'd3;
        #1;
        checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_flush_over_lu: got %b expected %b", ctl, C_REDIR); end
        tick();
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL redir_cleared_lu: got %b expected %b", ctl, C_LU); end
        tick();
        idle_inputs();
        // Pending redirect must survive an intervening D-stall.
        branch_taken_i = 1; icache_stall_i = 1;
        tick();
        branch_taken_i = 0; icache_stall_i = 0; dcache_stall_i = 1;
        #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL redir_dstall_ctl: got %b expected %b", ctl, C_ZERO); end
        tick();
        dcache_stall_i = 0;
        #1;
        checks++; if (ctl !== C_REDIR) begin errors++; $display("FAIL redir_after_dstall: got %b expected %b", ctl, C_REDIR); end
        tick();
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL redir_done: got %b expected %b", ctl, C_FREE); end
    endtask

    task automatic test_watchdog();
        dcache_stall_i = 1;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL wd_seven: got %b expected 0", stall_timeout_o); end
        dcache_stall_i = 0;
        tick();
        checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL wd_gap: got %b expected 0", stall_timeout_o); end
        dcache_stall_i = 1;
        for (int i = 0; i < 7; i++) tick();
        checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL wd_before_eighth: got %b expected 0", stall_timeout_o); end
        tick();
        checks++; if (stall_timeout_o !== 1'b1) begin errors++; $display("FAIL wd_eighth: got %b expected 1", stall_timeout_o); end
        dcache_stall_i = 0;
        tick(); tick();
        checks++; if (stall_timeout_o !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b expected 1", stall_timeout_o); end
    endtask

    task automatic test_reset_mid_stall();
        branch_taken_i = 1; icache_stall_i = 1;
        tick();
        icache_stall_i = 0; dcache_stall_i = 1;
        tick();
        checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL rstmid_pre_state: got %0d expected 2", state_o); end
        #2;
        rst_i = 0;
        #1;
        checks++; if (ctl !== C_ZERO) begin errors++; $display("FAIL rstmid_ctl: got %b expected %b", ctl, C_ZERO); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", state_o); end
        checks++; if (stall_timeout_o !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b expected 0", stall_timeout_o); end
        idle_inputs();
        tick(); tick();
        rst_i = 1;
        #1;
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL rstmid_release_ctl: got %b expected %b", ctl, C_FREE); end
        tick();
        checks++; if (ctl !== C_FREE) begin errors++; $display("FAIL rstmid_no_redir: got %b expected %b", ctl, C_FREE); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rstmid_release_state: got %0d expected 0", state_o); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_dstall();
        test_istall();
        test_redirect();
        test_watchdog();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
